// File: rtl/i2c_seq_pkg.sv
// Shared types for the I2C byte-register sequencer.
// Main and fetch state encodings plus default sync depth.
package i2c_seq_pkg;

  localparam int SYNC_DEF = 2;

  typedef enum logic [1:0] {
    M_IDLE,
    M_FIRST,
    M_WRITING,
    M_READING
  } main_st_t;

  typedef enum logic [1:0] {
    F_IDLE,
    F_REQ,
    F_CAP
  } fetch_st_t;

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchronizer for an asynchronous level.
// Provides the synced level and registered rise/fall pulses.
module i2c_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic start_async_rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES:0] sh;

  always_ff @(posedge clk or posedge start_async_rst) begin
    if (start_async_rst) begin
      sh   <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sh   <= {sh[STAGES-1:0], d};
      rise <= sh[STAGES-1] & ~sh[STAGES];
      fall <= ~sh[STAGES-1] & sh[STAGES];
    end
  end

  assign level = sh[STAGES-1];

endmodule

// File: rtl/i2c_reg_seq.sv
// Sequencer between i2c_slave and a byte register bank:
// pointer-then-data writes, prefetching reads, auto-increment.
module i2c_reg_seq
  import i2c_seq_pkg::*;
#(
  parameter int AW          = 4,
  parameter int SYNC_STAGES = SYNC_DEF
) (
  input  logic          clk,
  input  logic          start_async_rst,
  input  logic          i2c_start,
  input  logic          i2c_stop,
  input  logic          i2c_r_w,
  input  logic          i2c_data_vld,
  input  logic [7:0]    i2c_data_out,
  output logic [7:0]    i2c_data_in,
  output logic          i2c_ready,
  output logic [AW-1:0] reg_addr,
  output logic [7:0]    reg_wdata,
  output logic          reg_we,
  output logic          reg_re,
  input  logic [7:0]    reg_rdata
);

  logic start_lvl, start_ev, start_fall;
  logic stop_lvl, stop_ev, stop_fall;
  logic vld_lvl, vld_rise, byte_ev;
  logic rw_lvl, rw_rise, rw_fall;

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_start (
    .clk(clk), .start_async_rst(start_async_rst), .d(i2c_start),
    .level(start_lvl), .rise(start_ev), .fall(start_fall)
  );

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_stop (
    .clk(clk), .start_async_rst(start_async_rst), .d(i2c_stop),
    .level(stop_lvl), .rise(stop_ev), .fall(stop_fall)
  );

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_vld (
    .clk(clk), .start_async_rst(start_async_rst), .d(i2c_data_vld),
    .level(vld_lvl), .rise(vld_rise), .fall(byte_ev)
  );

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_rw (
    .clk(clk), .start_async_rst(start_async_rst), .d(i2c_r_w),
    .level(rw_lvl), .rise(rw_rise), .fall(rw_fall)
  );

  logic unused_sync;
  assign unused_sync = &{1'b0, start_lvl, start_fall, stop_lvl,
                         stop_fall, vld_lvl, vld_rise, rw_rise,
                         rw_fall};

  main_st_t  mst, mst_n;
  fetch_st_t fst, fst_n;
  logic [AW-1:0] ptr, ptr_n, we_addr;
  logic boot, req, we_n, cap;

  always_comb begin
    mst_n = mst;
    ptr_n = ptr;
    req   = boot;
    we_n  = 1'b0;
    unique case (mst)
      M_IDLE: ;
      M_FIRST: begin
        if (byte_ev) begin
          req = 1'b1;
          if (rw_lvl) begin
            ptr_n = ptr + AW'(1);
            mst_n = M_READING;
          end else begin
            ptr_n = i2c_data_out[AW-1:0];
            mst_n = M_WRITING;
          end
        end
      end
      M_WRITING: begin
        if (byte_ev) begin
          we_n  = 1'b1;
          ptr_n = ptr + AW'(1);
          req   = 1'b1;
        end
      end
      M_READING: begin
        if (byte_ev) begin
          ptr_n = ptr + AW'(1);
          req   = 1'b1;
        end
      end
      default: mst_n = M_IDLE;
    endcase
    // byte effects above land first; bus conditions override state
    if (start_ev)     mst_n = M_FIRST;
    else if (stop_ev) mst_n = M_IDLE;
  end

  always_comb begin
    fst_n = fst;
    cap   = 1'b0;
    unique case (fst)
      F_IDLE: if (req) fst_n = F_REQ;
      F_REQ:  if (!req && !reg_we) fst_n = F_CAP;
      F_CAP: begin
        if (req) begin
          fst_n = F_REQ;
        end else begin
          fst_n = F_IDLE;
          cap   = 1'b1;
        end
      end
      default: fst_n = F_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge start_async_rst) begin
    if (start_async_rst) begin
      mst         <= M_IDLE;
      fst         <= F_IDLE;
      ptr         <= '0;
      boot        <= 1'b1;
      i2c_ready   <= 1'b0;
      i2c_data_in <= 8'h00;
      reg_we      <= 1'b0;
      reg_wdata   <= 8'h00;
      we_addr     <= '0;
    end else begin
      mst       <= mst_n;
      fst       <= fst_n;
      ptr       <= ptr_n;
      boot      <= 1'b0;
      i2c_ready <= (fst_n == F_IDLE);
      reg_we    <= we_n;
      if (we_n) begin
        reg_wdata <= i2c_data_out;
        we_addr   <= ptr;
      end
      if (cap) i2c_data_in <= reg_rdata;
    end
  end

  // a pending write holds off the read strobe for one cycle
  assign reg_re   = (fst == F_REQ) && !reg_we;
  assign reg_addr = reg_we ? we_addr : ptr;

endmodule

// File: tb/tb_i2c_reg_seq.sv
// Randomized bench for i2c_reg_seq against a pointer/memory
// model of the register protocol.
module tb_i2c_reg_seq;

  localparam int AW = 4;
  localparam int NR = 16;

  logic          clk = 1'b0;
  logic          start_async_rst;
  logic          i2c_start, i2c_stop, i2c_r_w, i2c_data_vld;
  logic [7:0]    i2c_data_out;
  logic [7:0]    i2c_data_in;
  logic          i2c_ready;
  logic [AW-1:0] reg_addr;
  logic [7:0]    reg_wdata;
  logic          reg_we, reg_re;
  logic [7:0]    reg_rdata;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  mem   [NR];
  logic [7:0]  mem_m [NR];
  logic [11:0] exp_q [$];
  int          ptr_m;
  bit          in_first, is_rd;

  always #5 clk = ~clk;

  i2c_reg_seq #(.AW(AW), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .start_async_rst(start_async_rst),
    .i2c_start(i2c_start),
    .i2c_stop(i2c_stop),
    .i2c_r_w(i2c_r_w),
    .i2c_data_vld(i2c_data_vld),
    .i2c_data_out(i2c_data_out),
    .i2c_data_in(i2c_data_in),
    .i2c_ready(i2c_ready),
    .reg_addr(reg_addr),
    .reg_wdata(reg_wdata),
    .reg_we(reg_we),
    .reg_re(reg_re),
    .reg_rdata(reg_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // register bank seen by the DUT
  always @(posedge clk) begin
    if (reg_we) mem[reg_addr] <= reg_wdata;
    if (reg_re) reg_rdata <= mem[reg_addr];
  end

  always @(negedge clk) begin
    if (reg_we && !start_async_rst) begin
      chk("we_re_excl", {31'd0, reg_re}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("we_unexpected", {20'd0, reg_addr, reg_wdata}, 32'hFFFF);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        chk("we_addr", {28'd0, reg_addr}, {28'd0, e[11:8]});
        chk("we_data", {24'd0, reg_wdata}, {24'd0, e[7:0]});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start(input bit rw);
    i2c_r_w = rw;
    cyc(2);
    i2c_start = 1'b1;
    cyc(5);
    i2c_start = 1'b0;
    cyc(6);
    in_first = 1'b1;
    is_rd    = rw;
  endtask

  task automatic do_stop();
    i2c_stop = 1'b1;
    cyc(5);
    i2c_stop = 1'b0;
    cyc(6);
  endtask

  task automatic settle_chk(input string tag);
    chk({tag, "_din"}, {24'd0, i2c_data_in}, {24'd0, mem_m[ptr_m]});
    chk({tag, "_ptr"}, {28'd0, reg_addr}, ptr_m);
    chk({tag, "_rdy"}, {31'd0, i2c_ready}, 32'd1);
  endtask

  task automatic xfer(input logic [7:0] b);
    logic [3:0] p;
    if (!is_rd && in_first) begin
      ptr_m = b % NR;
    end else if (!is_rd) begin
      p = ptr_m[3:0];
      exp_q.push_back({p, b});
      mem_m[ptr_m] = b;
      ptr_m = (ptr_m + 1) % NR;
    end else begin
      ptr_m = (ptr_m + 1) % NR;
    end
    in_first     = 1'b0;
    i2c_data_out = b;
    cyc(2);
    i2c_data_vld = 1'b1;
    cyc(5);
    i2c_data_vld = 1'b0;
    cyc(14);
    settle_chk("byte");
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_din"}, {24'd0, i2c_data_in}, 32'h00);
    chk({tag, "_rdy"}, {31'd0, i2c_ready}, 32'd0);
    chk({tag, "_we"}, {31'd0, reg_we}, 32'd0);
    chk({tag, "_re"}, {31'd0, reg_re}, 32'd0);
    chk({tag, "_wd"}, {24'd0, reg_wdata}, 32'h00);
    chk({tag, "_ptr"}, {28'd0, reg_addr}, 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    for (int i = 0; i < NR; i++) begin
      mem[i]   = 8'($urandom);
      mem_m[i] = mem[i];
    end
    mem[0] = 8'h5A;
    mem_m[0] = 8'h5A;
    ptr_m = 0;
    in_first = 1'b0;
    is_rd = 1'b0;
    start_async_rst = 1'b1;
    i2c_start = 1'b0;
    i2c_stop = 1'b0;
    i2c_r_w = 1'b0;
    i2c_data_vld = 1'b0;
    i2c_data_out = 8'h00;
    cyc(3);
    chk_reset_outs("rst");
    start_async_rst = 1'b0;
    cyc(1);
    chk("boot_re1", {31'd0, reg_re}, 32'd1);
    chk("boot_addr", {28'd0, reg_addr}, 32'd0);
    chk("boot_rdy1", {31'd0, i2c_ready}, 32'd0);
    cyc(1);
    chk("boot_re2", {31'd0, reg_re}, 32'd0);
    chk("boot_rdy2", {31'd0, i2c_ready}, 32'd0);
    cyc(1);
    chk("boot_rdy3", {31'd0, i2c_ready}, 32'd1);
    chk("boot_din", {24'd0, i2c_data_in}, 32'h5A);
    cyc(4);

    do_start(1'b0);
    xfer(8'h03);
    xfer(8'h11);
    xfer(8'h22);
    do_stop();
    chk("w3_ptr", {28'd0, reg_addr}, 32'd5);

    do_start(1'b0);
    xfer(8'h0F);
    xfer(8'hAA);
    xfer(8'hBB);
    do_stop();
    chk("wrap_ptr", {28'd0, reg_addr}, 32'd1);

    mem[2] = 8'h77; mem_m[2] = 8'h77;
    mem[3] = 8'h88; mem_m[3] = 8'h88;
    do_start(1'b0);
    xfer(8'h02);
    chk("rs_pre", {24'd0, i2c_data_in}, 32'h77);
    do_start(1'b1);
    xfer(8'h00);
    chk("rs_rd1", {24'd0, i2c_data_in}, 32'h88);
    do_stop();

    do_start(1'b0);
    xfer(8'hF6);
    chk("hi_ign", {28'd0, reg_addr}, 32'd6);
    do_stop();

    do_start(1'b0);
    xfer(8'h05);
    i2c_data_out = 8'h99;
    i2c_data_vld = 1'b1;
    cyc(3);
    start_async_rst = 1'b1;
    cyc(2);
    chk_reset_outs("mid");
    i2c_data_vld = 1'b0;
    cyc(1);
    start_async_rst = 1'b0;
    ptr_m = 0;
    in_first = 1'b0;
    cyc(20);
    settle_chk("post_rst");

    for (int t = 0; t < 10; t++) begin
      do_start(1'($urandom_range(0, 1)));
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) xfer(8'($urandom));
      if ($urandom_range(0, 2) != 0) do_stop();
    end
    do_stop();
    cyc(20);
    chk("we_q_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
